// File: rtl/hack_rom_arbiter.sv
// Arbitrates the single-port Hack instruction memory between CPU fetch and the UART host loader.
// Optional write protection of the ROM image is enabled by defining ROM_WP_EN.
module hack_rom_arbiter #(
  parameter int AW       = 15,
  parameter int DW       = 16,
  parameter int RD_LAT   = 1,
  parameter int MAX_HOST = 8,
  parameter int TA_EN    = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cpu_req_i,
  input  logic [AW-1:0] cpu_addr_i,
  output logic          cpu_gnt_o,
  output logic          cpu_rvalid_o,
  output logic [DW-1:0] cpu_rdata_o,
  input  logic [15:0]   host_addr_i,
  input  logic          host_wvalid_i,
  input  logic [DW-1:0] host_wdata_i,
  output logic          host_wready_o,
  input  logic          host_rvalid_i,
  output logic          host_rready_o,
  output logic          host_rrvalid_o,
  output logic [DW-1:0] host_rdata_o,
  input  logic          wp_i,
  output logic          wp_err_o,
  output logic [AW-1:0] mem_addr_o,
  output logic          mem_read_o,
  output logic          mem_write_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic [DW-1:0] mem_rdata_i
);

  typedef enum logic [2:0] {S_IDLE, S_CPU, S_HRD, S_HWR, S_TA} state_t;

  state_t            state_q, state_d;
  logic [7:0]        burst_q, burst_d;
  logic [RD_LAT-1:0] tagValid_q, tagOwner_q;
  logic              wpErr_q;

  logic          gntW, gntR, gntC, taCycle, forced, wpDrop;
  logic [AW-1:0] hostWord;
  logic          unusedBits;

  assign hostWord   = host_addr_i[AW:1];
  assign unusedBits = ^{host_addr_i, wp_i};

`ifdef ROM_WP_EN
  assign wpDrop = gntW && wp_i;
`else
  assign wpDrop = 1'b0;
`endif

  // A dead cycle on the bus takes precedence over everything, including the forced CPU slot.
  always_comb begin
    taCycle = (TA_EN != 0) && (state_q == S_HWR) && !host_wvalid_i &&
              (host_rvalid_i || cpu_req_i);
    forced  = cpu_req_i && (burst_q == 8'(MAX_HOST));
    gntW    = 1'b0;
    gntR    = 1'b0;
    gntC    = 1'b0;
    if (rst_n && !taCycle) begin
      if (forced)             gntC = 1'b1;
      else if (host_wvalid_i) gntW = 1'b1;
      else if (host_rvalid_i) gntR = 1'b1;
      else if (cpu_req_i)     gntC = 1'b1;
    end
  end

  always_comb begin
    if (taCycle)   state_d = S_TA;
    else if (gntW) state_d = wpDrop ? S_IDLE : S_HWR;
    else if (gntR) state_d = S_HRD;
    else if (gntC) state_d = S_CPU;
    else           state_d = S_IDLE;

    burst_d = burst_q;
    if (!cpu_req_i || gntC)
      burst_d = 8'd0;
    else if ((gntW || gntR) && (burst_q < 8'(MAX_HOST)))
      burst_d = burst_q + 8'd1;
  end

  // Tag pipe follows every issued read so returning data reaches only its owner (owner 1 = host).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      burst_q    <= 8'd0;
      tagValid_q <= '0;
      tagOwner_q <= '0;
      wpErr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      burst_q <= burst_d;
      for (int i = RD_LAT - 1; i > 0; i--) begin
        tagValid_q[i] <= tagValid_q[i-1];
        tagOwner_q[i] <= tagOwner_q[i-1];
      end
      tagValid_q[0] <= gntR || gntC;
      tagOwner_q[0] <= gntR;
      if (wpDrop) wpErr_q <= 1'b1;
    end
  end

  assign cpu_gnt_o      = gntC;
  assign host_wready_o  = gntW;
  assign host_rready_o  = gntR;
  assign mem_read_o     = gntR || gntC;
  assign mem_write_o    = gntW && !wpDrop;
  assign mem_addr_o     = !rst_n ? '0 : ((gntW || gntR) ? hostWord : cpu_addr_i);
  assign mem_wdata_o    = rst_n ? host_wdata_i : '0;
  assign cpu_rvalid_o   = rst_n && tagValid_q[RD_LAT-1] && !tagOwner_q[RD_LAT-1];
  assign host_rrvalid_o = rst_n && tagValid_q[RD_LAT-1] &&  tagOwner_q[RD_LAT-1];
  assign cpu_rdata_o    = rst_n ? mem_rdata_i : '0;
  assign host_rdata_o   = rst_n ? mem_rdata_i : '0;
  assign wp_err_o       = wpErr_q;

endmodule

// File: tb/tb_hack_rom_arbiter.sv
// Directed bench for hack_rom_arbiter: instance A (RD_LAT=1, TA_EN=0) and B (RD_LAT=3, TA_EN=1)
// share stimulus and each has its own memory model.
module tb_hack_rom_arbiter;

  logic        clk = 1'b0;
  logic        rstN;
  logic        cpuReq, hostW, hostR, wp;
  logic [14:0] cpuAddr;
  logic [15:0] hostAddr, hostWdata;

  logic        aGnt, aRvalid, aWready, aRready, aRrvalid, aWpErr, aMemRd, aMemWr;
  logic [15:0] aCpuRdata, aHostRdata, aMemWdata, aMemRdata;
  logic [14:0] aMemAddr;
  logic        bGnt, bRvalid, bWready, bRready, bRrvalid, bWpErr, bMemRd, bMemWr;
  logic [15:0] bCpuRdata, bHostRdata, bMemWdata, bMemRdata;
  logic [14:0] bMemAddr;

  logic [15:0] memA [64];
  logic [15:0] memB [64];
  logic [15:0] bPipe1, bPipe2;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hack_rom_arbiter #(.AW(15), .DW(16), .RD_LAT(1), .MAX_HOST(8), .TA_EN(0)) dutA (
    .clk(clk), .rst_n(rstN), .cpu_req_i(cpuReq), .cpu_addr_i(cpuAddr),
    .cpu_gnt_o(aGnt), .cpu_rvalid_o(aRvalid), .cpu_rdata_o(aCpuRdata),
    .host_addr_i(hostAddr), .host_wvalid_i(hostW), .host_wdata_i(hostWdata),
    .host_wready_o(aWready), .host_rvalid_i(hostR), .host_rready_o(aRready),
    .host_rrvalid_o(aRrvalid), .host_rdata_o(aHostRdata), .wp_i(wp), .wp_err_o(aWpErr),
    .mem_addr_o(aMemAddr), .mem_read_o(aMemRd), .mem_write_o(aMemWr),
    .mem_wdata_o(aMemWdata), .mem_rdata_i(aMemRdata));

  hack_rom_arbiter #(.AW(15), .DW(16), .RD_LAT(3), .MAX_HOST(8), .TA_EN(1)) dutB (
    .clk(clk), .rst_n(rstN), .cpu_req_i(cpuReq), .cpu_addr_i(cpuAddr),
    .cpu_gnt_o(bGnt), .cpu_rvalid_o(bRvalid), .cpu_rdata_o(bCpuRdata),
    .host_addr_i(hostAddr), .host_wvalid_i(hostW), .host_wdata_i(hostWdata),
    .host_wready_o(bWready), .host_rvalid_i(hostR), .host_rready_o(bRready),
    .host_rrvalid_o(bRrvalid), .host_rdata_o(bHostRdata), .wp_i(wp), .wp_err_o(bWpErr),
    .mem_addr_o(bMemAddr), .mem_read_o(bMemRd), .mem_write_o(bMemWr),
    .mem_wdata_o(bMemWdata), .mem_rdata_i(bMemRdata));

  // Memory models: one-cycle read for A, three-cycle read pipeline for B.
  always @(posedge clk) begin
    if (aMemRd) aMemRdata <= memA[aMemAddr[5:0]];
    if (aMemWr) memA[aMemAddr[5:0]] <= aMemWdata;
    if (bMemRd) bPipe1 <= memB[bMemAddr[5:0]];
    bPipe2    <= bPipe1;
    bMemRdata <= bPipe2;
    if (bMemWr) memB[bMemAddr[5:0]] <= bMemWdata;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle's inputs, then settle to the sampling point mid-cycle.
  task automatic applyStimulus(input logic req, input logic [14:0] ca, input logic [15:0] ha,
                               input logic w, input logic [15:0] wd, input logic r, input logic p);
    cpuReq = req; cpuAddr = ca; hostAddr = ha; hostW = w; hostWdata = wd; hostR = r; wp = p;
    #3;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      memA[i] = 16'h1000 + 16'(i);
      memB[i] = 16'h1000 + 16'(i);
    end
    rstN = 1'b0;
    applyStimulus(1'b1, 15'd0, 16'h0004, 1'b1, 16'h5555, 1'b1, 1'b1);
    tick(); tick();
    applyStimulus(1'b1, 15'd0, 16'h0004, 1'b1, 16'h5555, 1'b1, 1'b1);
    checkOutput("rst_cpu_gnt", aGnt, 0);
    checkOutput("rst_wready", aWready, 0);
    checkOutput("rst_mem_read", aMemRd, 0);
    checkOutput("rst_mem_write", aMemWr, 0);
    checkOutput("rst_mem_addr", aMemAddr, 0);
    checkOutput("rst_wp_err", aWpErr, 0);
    checkOutput("rst_rvalid", aRvalid, 0);

    // CPU-only fetch stream
    tick(); rstN = 1'b1;
    applyStimulus(1'b1, 15'd0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0);
    checkOutput("fetch0_gnt", aGnt, 1);
    checkOutput("fetch0_addr", aMemAddr, 0);
    checkOutput("fetch0_rvalid", aRvalid, 0);
    for (int i = 1; i < 3; i++) begin
      tick();
      applyStimulus(1'b1, 15'(i), 16'h0, 1'b0, 16'h0, 1'b0, 1'b0);
      checkOutput("fetch_gnt", aGnt, 1);
      checkOutput("fetch_rvalid", aRvalid, 1);
      checkOutput("fetch_rdata", aCpuRdata, 32'h1000 + 32'(i - 1));
    end
    tick();
    applyStimulus(1'b0, 15'd0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0);
    checkOutput("fetch_tail_rvalid", aRvalid, 1);
    checkOutput("fetch_tail_rdata", aCpuRdata, 32'h1002);
    checkOutput("idle_mem_read", aMemRd, 0);

    // Host write beats a pending CPU request; B then inserts a turnaround
    tick();
    applyStimulus(1'b1, 15'd8, 16'h0010, 1'b1, 16'hABCD, 1'b0, 1'b0);
    checkOutput("hw_wready", aWready, 1);
    checkOutput("hw_mem_addr", aMemAddr, 8);
    checkOutput("hw_cpu_gnt", aGnt, 0);
    checkOutput("hw_mem_write", aMemWr, 1);
    checkOutput("hw_mem_wdata", aMemWdata, 32'hABCD);
    checkOutput("hw_b_wready", bWready, 1);
    tick();
    applyStimulus(1'b1, 15'd8, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0);
    checkOutput("ta0_a_gnt", aGnt, 1);
    checkOutput("ta_b_gnt", bGnt, 0);
    checkOutput("ta_b_mem_read", bMemRd, 0);
    tick();
    applyStimulus(1'b1, 15'd8, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0);
    checkOutput("ta_b_gnt_after", bGnt, 1);
    checkOutput("readback_rvalid", aRvalid, 1);
    checkOutput("readback_rdata", aCpuRdata, 32'hABCD);
    tick();
    applyStimulus(1'b0, 15'd0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0);

    // Simultaneous host write and read: write first
    tick();
    applyStimulus(1'b0, 15'd0, 16'h0030, 1'b1, 16'h7777, 1'b1, 1'b0);
    checkOutput("wr_rd_wready", aWready, 1);
    checkOutput("wr_rd_rready", aRready, 0);
    tick();
    applyStimulus(1'b0, 15'd0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 15'd0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0);

    // Starvation bound: 8 host reads then one forced CPU slot, repeating
    for (int k = 0; k < 27; k++) begin
      tick();
      applyStimulus(1'b1, 15'd3, 16'h0004, 1'b0, 16'h0, 1'b1, 1'b0);
      checkOutput("starve_rready", aRready, (k % 9 == 8) ? 0 : 1);
      checkOutput("starve_cpu_gnt", aGnt, (k % 9 == 8) ? 1 : 0);
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      applyStimulus(1'b0, 15'd0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0);
    end

    // RD_LAT=3 host read latency on B
    tick();
    applyStimulus(1'b0, 15'd0, 16'h0004, 1'b0, 16'h0, 1'b1, 1'b0);
    checkOutput("b_rd_rready", bRready, 1);
    for (int k = 1; k <= 3; k++) begin
      tick();
      applyStimulus(1'b0, 15'd0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0);
      checkOutput("b_rd_rrvalid", bRrvalid, (k == 3) ? 1 : 0);
      if (k == 3) checkOutput("b_rd_rdata", bHostRdata, 32'h1002);
    end
    tick();
    applyStimulus(1'b0, 15'd0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0);

    // Reset one cycle after a B host read drops the in-flight tag
    tick();
    applyStimulus(1'b0, 15'd0, 16'h0004, 1'b0, 16'h0, 1'b1, 1'b0);
    checkOutput("b_rst_rready", bRready, 1);
    tick(); rstN = 1'b0;
    applyStimulus(1'b1, 15'd0, 16'h0004, 1'b0, 16'h0, 1'b1, 1'b0);
    checkOutput("b_in_rst_rready", bRready, 0);
    checkOutput("b_in_rst_mem_read", bMemRd, 0);
    checkOutput("b_in_rst_rrvalid", bRrvalid, 0);
    tick(); rstN = 1'b1;
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b0, 15'd0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0);
      checkOutput("b_post_rst_rrvalid", bRrvalid, 0);
      tick();
    end

    // Write protection
    applyStimulus(1'b0, 15'd0, 16'h0020, 1'b1, 16'h1234, 1'b0, 1'b1);
    checkOutput("wp_wready", aWready, 1);
`ifdef ROM_WP_EN
    checkOutput("wp_mem_write", aMemWr, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      applyStimulus(1'b0, 15'd0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0);
      checkOutput("wp_err_held", aWpErr, 1);
    end
    tick(); rstN = 1'b0;
    tick(); rstN = 1'b1;
    applyStimulus(1'b0, 15'd0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0);
    checkOutput("wp_err_cleared", aWpErr, 0);
`else
    checkOutput("wp_ignored_mem_write", aMemWr, 1);
    tick();
    applyStimulus(1'b0, 15'd0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0);
    checkOutput("wp_err_tied", aWpErr, 0);
`endif

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
